// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract with round-to-nearest-even.
// Alignment and normalisation move one bit per cycle to keep the datapath small.
module fp_addsub_seq #(
  parameter int SKIP_SHIFT = 27
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_operation,
  input  logic [31:0] i_data_a,
  input  logic [31:0] i_data_b,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_cal_result,
  output logic [2:0]  o_dbg_state
);

  // Handshake: a request is taken on a rising edge where i_valid=1 and o_busy=0.
  // o_busy stays high from the next cycle through the single o_valid cycle, and
  // i_valid is ignored for that whole window.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UNPACK  = 3'd1,
    S_ALIGN   = 3'd2,
    S_ADD     = 3'd3,
    S_NORM    = 3'd4,
    S_ROUND   = 3'd5,
    S_SPECIAL = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  localparam logic [7:0] SKIP_W = 8'(SKIP_SHIFT);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic               sign_l_q, sign_l_d;
  logic               sign_s_q, sign_s_d;
  logic signed [9:0]  exp_l_q, exp_l_d;
  logic [27:0]        man_l_q, man_l_d;
  logic [26:0]        man_s_q, man_s_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic [31:0]        out_q, out_d;
  logic               valid_q, valid_d;

  logic [7:0]         ea, eb;
  logic [30:0]        mag_a, mag_b;
  logic [26:0]        ma, mb;
  logic               swap_w;
  logic               a_nan, b_nan, a_inf, b_inf;
  logic               sub_w;
  logic [27:0]        sum_w;
  logic               rnd_inc;
  logic [24:0]        rnd_sum;
  logic signed [9:0]  rnd_exp;
  logic [22:0]        rnd_frac;

  // Subnormals are treated as signed zero, so they get a zero magnitude and mantissa.
  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign mag_a  = (ea == 8'd0) ? 31'd0 : a_q[30:0];
  assign mag_b  = (eb == 8'd0) ? 31'd0 : b_q[30:0];
  assign ma     = (ea == 8'd0) ? 27'd0 : {1'b1, a_q[22:0], 3'b000};
  assign mb     = (eb == 8'd0) ? 27'd0 : {1'b1, b_q[22:0], 3'b000};
  assign swap_w = mag_b > mag_a;

  assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);

  assign sub_w  = sign_l_q ^ sign_s_q;
  assign sum_w  = sub_w ? (man_l_q - {1'b0, man_s_q}) : (man_l_q + {1'b0, man_s_q});

  // G = bit2, R|S = bits1:0, LSB = bit3; a carry out of the rounded mantissa bumps the exponent.
  assign rnd_inc  = man_l_q[2] & (man_l_q[1] | man_l_q[0] | man_l_q[3]);
  assign rnd_sum  = {1'b0, man_l_q[26:3]} + {24'd0, rnd_inc};
  assign rnd_exp  = exp_l_q + $signed({9'd0, rnd_sum[24]});
  assign rnd_frac = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_l_q <= 1'b0;
      sign_s_q <= 1'b0;
      exp_l_q  <= '0;
      man_l_q  <= '0;
      man_s_q  <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_l_q <= sign_l_d;
      sign_s_q <= sign_s_d;
      exp_l_q  <= exp_l_d;
      man_l_q  <= man_l_d;
      man_s_q  <= man_s_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_l_d = sign_l_q;
    sign_s_d = sign_s_q;
    exp_l_d  = exp_l_q;
    man_l_d  = man_l_q;
    man_s_d  = man_s_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    out_d    = out_q;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_valid && !o_busy) begin
          a_d     = i_data_a;
          b_d     = {i_data_b[31] ^ i_operation, i_data_b[30:0]};
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        if ((ea == 8'hFF) || (eb == 8'hFF)) begin
          state_d = S_SPECIAL;
        end else if (swap_w) begin
          sign_l_d = b_q[31];
          sign_s_d = a_q[31];
          exp_l_d  = $signed({2'b00, eb});
          man_l_d  = {1'b0, mb};
          man_s_d  = ma;
          cnt_d    = eb - ea;
          state_d  = S_ALIGN;
        end else begin
          sign_l_d = a_q[31];
          sign_s_d = b_q[31];
          exp_l_d  = $signed({2'b00, ea});
          man_l_d  = {1'b0, ma};
          man_s_d  = mb;
          cnt_d    = ea - eb;
          state_d  = S_ALIGN;
        end
      end

      S_ALIGN: begin
        if (cnt_q >= SKIP_W) begin
          man_s_d = {26'd0, |man_s_q};
          cnt_d   = 8'd0;
          state_d = S_ADD;
        end else if (cnt_q == 8'd0) begin
          state_d = S_ADD;
        end else begin
          man_s_d = {1'b0, man_s_q[26:2], man_s_q[1] | man_s_q[0]};
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_ADD;
        end
      end

      S_ADD: begin
        if (sum_w == 28'd0) begin
          // Cancellation gives +0; only like-signed zeros keep their sign.
          res_d   = {(sub_w ? 1'b0 : sign_l_q), 31'd0};
          state_d = S_DONE;
        end else begin
          man_l_d = sum_w;
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        if (man_l_q[27]) begin
          man_l_d = {1'b0, man_l_q[27:2], man_l_q[1] | man_l_q[0]};
          exp_l_d = exp_l_q + 10'sd1;
          state_d = S_ROUND;
        end else if (!man_l_q[26] && (exp_l_q > 10'sd1)) begin
          man_l_d = {man_l_q[26:0], 1'b0};
          exp_l_d = exp_l_q - 10'sd1;
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        if (rnd_exp >= 10'sd255) begin
          res_d = {sign_l_q, 8'hFF, 23'd0};
        end else if ((rnd_exp <= 10'sd0) || !man_l_q[26]) begin
          res_d = {sign_l_q, 31'd0};
        end else begin
          res_d = {sign_l_q, rnd_exp[7:0], rnd_frac};
        end
        state_d = S_DONE;
      end

      S_SPECIAL: begin
        if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] ^ b_q[31]))) begin
          res_d = 32'h7FC0_0000;
        end else begin
          res_d = {(a_inf ? a_q[31] : b_q[31]), 8'hFF, 23'd0};
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        out_d   = res_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // valid_q extends busy over the result cycle, after the FSM has already returned to IDLE.
  assign o_busy       = (state_q != S_IDLE) || valid_q;
  assign o_valid      = valid_q;
  assign o_cal_result = out_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed and random add/sub pairs with a result scoreboard,
// latency, handshake and asynchronous-reset checks.
module tb_fp_addsub_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_operation;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_cal_result;
  logic [2:0]  o_dbg_state;

  int          n_checks;
  int          n_errors;
  int          n_valid;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  fp_addsub_seq #(.SKIP_SHIFT(27)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_operation  (i_operation),
    .i_data_a     (i_data_a),
    .i_data_b     (i_data_b),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_cal_result (o_cal_result),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        check(tag_q.pop_front(), o_cal_result, exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (o_busy && g < 200) begin
      @(negedge i_clk);
      g++;
    end
    if (o_busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] exp, output int lat);
    int g;
    wait_idle();
    @(negedge i_clk);
    i_valid     = 1'b1;
    i_data_a    = a;
    i_data_b    = b;
    i_operation = op;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    lat = 0;
    g   = 0;
    @(negedge i_clk);
    i_valid = 1'b0;
    while (!o_valid && g < 200) begin
      @(negedge i_clk);
      lat++;
      g++;
    end
    if (!o_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
      void'(tag_q.pop_back());
    end else begin
      check({tag, "_busy_on_valid"}, {31'd0, o_busy}, 32'd1);
      @(negedge i_clk);
      check({tag, "_valid_pulse"}, {31'd0, o_valid}, 32'd0);
      check({tag, "_busy_after"}, {31'd0, o_busy}, 32'd0);
    end
  endtask

  initial begin
    int          lat;
    int          base;
    int          g;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [31:0] x;

    n_checks    = 0;
    n_errors    = 0;
    n_valid     = 0;
    i_rst_n     = 1'b0;
    i_valid     = 1'b0;
    i_operation = 1'b0;
    i_data_a    = '0;
    i_data_b    = '0;
    repeat (3) @(negedge i_clk);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_result", o_cal_result, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    do_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, lat);
    do_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, lat);
    do_op("m3_plus_3", 32'hC0400000, 32'h40400000, 1'b0, 32'h00000000, lat);
    do_op("negz_plus_negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, lat);
    do_op("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, lat);
    do_op("tie_odd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, lat);
    do_op("large_gap", 32'h4F800000, 32'h3F800000, 1'b0, 32'h4F800000, lat);
    check("large_gap_lat_le6", {31'd0, (lat <= 6)}, 32'd1);
    do_op("normalise", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, lat);
    do_op("two_minus_one", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, lat);
    do_op("one5_plus_one5", 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, lat);
    do_op("subnormal_in", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, lat);
    do_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, lat);
    do_op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, lat);
    check("special_lat", lat, 32'd3);
    do_op("neginf_plus_one", 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, lat);
    do_op("nan_in", 32'h3F800000, 32'h7FC00001, 1'b0, 32'h7FC00000, lat);

    // x+x doubles the exponent exactly; x-x cancels to +0
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      e = 8'($urandom_range(1, 253));
      f = 23'($urandom_range(0, 32'h7FFFFF));
      x = {s, e, f};
      do_op("rand_double", x, x, 1'b0, {s, e + 8'd1, f}, lat);
      do_op("rand_cancel", x, x, 1'b1, 32'h00000000, lat);
    end

    // i_valid held during busy must not start a second operation
    wait_idle();
    base = n_valid;
    @(negedge i_clk);
    i_valid     = 1'b1;
    i_data_a    = 32'h3F800000;
    i_data_b    = 32'h3F800000;
    i_operation = 1'b0;
    exp_q.push_back(32'h40000000);
    tag_q.push_back("busy_first");
    @(negedge i_clk);
    i_data_a = 32'h40400000;
    i_data_b = 32'h40400000;
    repeat (3) @(negedge i_clk);
    i_valid = 1'b0;
    repeat (40) @(negedge i_clk);
    check("busy_ignore_count", n_valid - base, 32'd1);

    // asynchronous reset while aligning
    wait_idle();
    @(negedge i_clk);
    i_valid     = 1'b1;
    i_data_a    = 32'h3F800000;
    i_data_b    = 32'h34000000;
    i_operation = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0;
    g = 0;
    while (o_dbg_state != 3'd2 && g < 20) begin
      @(negedge i_clk);
      g++;
    end
    check("reached_align", {29'd0, o_dbg_state}, 32'd2);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_result", o_cal_result, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    base = n_valid;
    do_op("after_reset", 32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, lat);
    repeat (10) @(negedge i_clk);
    check("after_reset_count", n_valid - base, 32'd1);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
